// File: rtl/drt_device_finder_if.sv
// Wishbone read-master bus bundle used by drt_device_finder toward the DRT slave.
interface drt_device_finder_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/drt_device_finder.sv
// Walks the device ROM table over Wishbone and returns the Nth entry matching a device ID.
// Optional macro DRT_FINDER_CACHE_EN keeps the header entry count across searches.
//
// state      | meaning
// IDLE       | waiting for find_stb_i
// HDR_ID     | reading header word0, checking table ID
// HDR_NUM    | reading header word1, entry count
// ENT_ID     | reading word0 of entry idx, matching
// ENT_INFO   | reading word1 of the matched entry
// ENT_MEM    | reading word2 of the matched entry
// ENT_SIZE   | reading word3 of the matched entry
// FIN        | done pulse, back to IDLE
module drt_device_finder #(
  parameter logic [31:0] DRT_BASE   = 32'h0000_0000,
  parameter logic [31:0] HDR_WORDS  = 32'd8,
  parameter logic [31:0] DEV_WORDS  = 32'd8,
  parameter logic [15:0] EXP_DRT_ID = 16'h0001,
  parameter logic [7:0]  MAX_DEV    = 8'd255,
  parameter logic [15:0] TIMEOUT    = 16'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        find_stb_i,
  input  logic [31:0] find_id_i,
  input  logic [7:0]  find_inst_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        found_o,
  output logic        err_o,
  output logic [7:0]  dev_index_o,
  output logic [31:0] dev_info_o,
  output logic [31:0] dev_mem_off_o,
  output logic [31:0] dev_size_o,
  drt_device_finder_if.master wb
);

`ifdef DRT_FINDER_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_HDR_ID   = 3'd1;
  localparam logic [2:0] S_HDR_NUM  = 3'd2;
  localparam logic [2:0] S_ENT_ID   = 3'd3;
  localparam logic [2:0] S_ENT_INFO = 3'd4;
  localparam logic [2:0] S_ENT_MEM  = 3'd5;
  localparam logic [2:0] S_ENT_SIZE = 3'd6;
  localparam logic [2:0] S_FIN      = 3'd7;

  logic [2:0]  state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        wait_low_q, wait_low_d;
  logic [31:0] adr_q, adr_d;
  logic [15:0] timer_q, timer_d;
  logic [31:0] id_q, id_d;
  logic [7:0]  inst_q, inst_d;
  logic [7:0]  ndev_q, ndev_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  mcnt_q, mcnt_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic        found_q, found_d;
  logic        err_q, err_d;
  logic [7:0]  index_q, index_d;
  logic [31:0] info_q, info_d;
  logic [31:0] mem_q, mem_d;
  logic [31:0] size_q, size_d;

  logic [31:0] rd_word;
  logic [31:0] ent_base;
  logic [31:0] rd_adr;
  logic [7:0]  hdr_ndev;
  logic [8:0]  idx_inc;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    wait_low_d  = wait_low_q;
    adr_d       = adr_q;
    timer_d     = timer_q;
    id_d        = id_q;
    inst_d      = inst_q;
    ndev_d      = ndev_q;
    idx_d       = idx_q;
    mcnt_d      = mcnt_q;
    hdr_valid_d = hdr_valid_q;
    found_d     = found_q;
    err_d       = err_q;
    index_d     = index_q;
    info_d      = info_q;
    mem_d       = mem_q;
    size_d      = size_q;

    rd_word  = wb.wbm_dat_i;
    ent_base = DRT_BASE + HDR_WORDS + 32'(idx_q) * DEV_WORDS;
    hdr_ndev = (rd_word[7:0] > MAX_DEV) ? MAX_DEV : rd_word[7:0];
    idx_inc  = {1'b0, idx_q} + 9'd1;

    case (state_q)
      S_HDR_ID:   rd_adr = DRT_BASE;
      S_HDR_NUM:  rd_adr = DRT_BASE + 32'd1;
      S_ENT_ID:   rd_adr = ent_base;
      S_ENT_INFO: rd_adr = ent_base + 32'd1;
      S_ENT_MEM:  rd_adr = ent_base + 32'd2;
      S_ENT_SIZE: rd_adr = ent_base + 32'd3;
      default:    rd_adr = DRT_BASE;
    endcase

    // The slave holds ack until it sees stb low; never start a read over a stale ack.
    if (wait_low_q && !wb.wbm_ack_i) wait_low_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (find_stb_i) begin
          id_d    = find_id_i;
          inst_d  = find_inst_i;
          found_d = 1'b0;
          err_d   = 1'b0;
          idx_d   = 8'd0;
          mcnt_d  = 8'd0;
          if (hdr_valid_q) state_d = (ndev_q == 8'd0) ? S_FIN : S_ENT_ID;
          else             state_d = S_HDR_ID;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: begin
        if (!cyc_q) begin
          if (!(wait_low_q && wb.wbm_ack_i)) begin
            cyc_d   = 1'b1;
            adr_d   = rd_adr;
            timer_d = TIMEOUT;
          end
        end else if (wb.wbm_ack_i) begin
          cyc_d      = 1'b0;
          wait_low_d = 1'b1;
          case (state_q)
            S_HDR_ID: begin
              if (rd_word[31:16] != EXP_DRT_ID) begin
                err_d   = 1'b1;
                state_d = S_FIN;
              end else begin
                state_d = S_HDR_NUM;
              end
            end
            S_HDR_NUM: begin
              ndev_d = hdr_ndev;
              if (CACHE_EN) hdr_valid_d = 1'b1;
              state_d = (hdr_ndev == 8'd0) ? S_FIN : S_ENT_ID;
            end
            S_ENT_ID: begin
              if (rd_word == id_q && mcnt_q == inst_q) begin
                index_d = idx_q;
                state_d = S_ENT_INFO;
              end else begin
                if (rd_word == id_q) mcnt_d = mcnt_q + 8'd1;
                if (idx_inc == {1'b0, ndev_q}) state_d = S_FIN;
                else                           idx_d   = idx_q + 8'd1;
              end
            end
            S_ENT_INFO: begin
              info_d  = rd_word;
              state_d = S_ENT_MEM;
            end
            S_ENT_MEM: begin
              mem_d   = rd_word;
              state_d = S_ENT_SIZE;
            end
            S_ENT_SIZE: begin
              size_d  = rd_word;
              found_d = 1'b1;
              state_d = S_FIN;
            end
            default: ;
          endcase
        end else if (timer_q <= 16'd1) begin
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          found_d = 1'b0;
          state_d = S_FIN;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      wait_low_q  <= 1'b0;
      adr_q       <= '0;
      timer_q     <= '0;
      id_q        <= '0;
      inst_q      <= '0;
      ndev_q      <= '0;
      idx_q       <= '0;
      mcnt_q      <= '0;
      hdr_valid_q <= 1'b0;
      found_q     <= 1'b0;
      err_q       <= 1'b0;
      index_q     <= '0;
      info_q      <= '0;
      mem_q       <= '0;
      size_q      <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      wait_low_q  <= wait_low_d;
      adr_q       <= adr_d;
      timer_q     <= timer_d;
      id_q        <= id_d;
      inst_q      <= inst_d;
      ndev_q      <= ndev_d;
      idx_q       <= idx_d;
      mcnt_q      <= mcnt_d;
      hdr_valid_q <= hdr_valid_d;
      found_q     <= found_d;
      err_q       <= err_d;
      index_q     <= index_d;
      info_q      <= info_d;
      mem_q       <= mem_d;
      size_q      <= size_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_FIN);
  assign found_o       = found_q;
  assign err_o         = err_q;
  assign dev_index_o   = index_q;
  assign dev_info_o    = info_q;
  assign dev_mem_off_o = mem_q;
  assign dev_size_o    = size_q;

  assign wb.wbm_cyc_o = cyc_q;
  assign wb.wbm_stb_o = cyc_q;
  assign wb.wbm_we_o  = 1'b0;
  assign wb.wbm_sel_o = 4'hF;
  assign wb.wbm_adr_o = adr_q;
  assign wb.wbm_dat_o = 32'h0;

endmodule

// File: tb/tb_drt_device_finder.sv
// Scoreboard bench for drt_device_finder: ROM-backed Wishbone slave, expected results
// queued at each start and checked by a monitor on every done pulse.
module tb_drt_device_finder;
  logic        clk = 1'b0;
  logic        rst;
  logic        find_stb;
  logic [31:0] find_id;
  logic [7:0]  find_inst;
  logic        busy, done, found, err;
  logic [7:0]  dev_index;
  logic [31:0] dev_info, dev_mem_off, dev_size;
  logic        ack_en;

  drt_device_finder_if wb();

  drt_device_finder dut (
    .clk(clk), .rst(rst),
    .find_stb_i(find_stb), .find_id_i(find_id), .find_inst_i(find_inst),
    .busy_o(busy), .done_o(done), .found_o(found), .err_o(err),
    .dev_index_o(dev_index), .dev_info_o(dev_info),
    .dev_mem_off_o(dev_mem_off), .dev_size_o(dev_size),
    .wb(wb.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        found;
    logic        err;
    logic        chk;
    logic [7:0]  idx;
    logic [31:0] info;
    logic [31:0] mem;
    logic [31:0] size;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_log[$];
  logic [31:0] rom [0:63];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic        prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // ROM slave: registered ack held while stb is high, logs each accepted read address.
  always @(posedge clk) begin
    if (wb.wbm_cyc_o && wb.wbm_stb_o && wb.wbm_ack_i) rd_log.push_back(wb.wbm_adr_o);
    if (rst) wb.wbm_ack_i <= 1'b0;
    else     wb.wbm_ack_i <= wb.wbm_cyc_o && wb.wbm_stb_o && ack_en;
    wb.wbm_dat_i <= rom[wb.wbm_adr_o[5:0]];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (done && prev_done) check("done_one_cycle", 32'(done && prev_done), 32'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("found", 32'(found), 32'(e.found));
          check("err", 32'(err), 32'(e.err));
          if (e.chk) begin
            check("dev_index", 32'(dev_index), 32'(e.idx));
            check("dev_info", dev_info, e.info);
            check("dev_mem_off", dev_mem_off, e.mem);
            check("dev_size", dev_size, e.size);
          end
        end
      end
    end
    prev_done = done;
  end

  task automatic push_exp(input logic f, input logic e, input logic c, input logic [7:0] idx,
                          input logic [31:0] info, input logic [31:0] mem, input logic [31:0] size);
    exp_t x;
    x.found = f; x.err = e; x.chk = c; x.idx = idx; x.info = info; x.mem = mem; x.size = size;
    exp_q.push_back(x);
  endtask

  task automatic set_entry(input int n, input logic [31:0] id, input logic [31:0] info,
                           input logic [31:0] mem, input logic [31:0] size);
    rom[8 + 8*n]     = id;
    rom[8 + 8*n + 1] = info;
    rom[8 + 8*n + 2] = mem;
    rom[8 + 8*n + 3] = size;
  endtask

  task automatic load_two_entry_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    rom[0] = 32'h0001_0001;
    rom[1] = 32'h0000_0002;
    set_entry(0, 32'h0001_0005, 32'hA000_0000, 32'hB000_0000, 32'h0000_0100);
    set_entry(1, 32'h0001_0002, 32'hA000_0001, 32'hB000_1000, 32'h0000_0200);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    rd_log.delete();
  endtask

  task automatic start_find(input logic [31:0] id, input logic [7:0] inst);
    @(negedge clk);
    find_stb = 1'b1; find_id = id; find_inst = inst;
    @(negedge clk);
    find_stb = 1'b0;
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max && !done; i++) @(negedge clk);
    if (!done) check("done_timeout", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (rd_log.size() > i) ? rd_log[i] : 32'hFFFF_FFFF;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; find_stb = 1'b0; find_id = '0; find_inst = '0; ack_en = 1'b1;
    load_two_entry_rom();
    do_reset();

    // reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_index", 32'(dev_index), 32'd0);
    check("rst_info", dev_info, 32'd0);
    check("rst_mem", dev_mem_off, 32'd0);
    check("rst_size", dev_size, 32'd0);
    check("rst_cyc", 32'(wb.wbm_cyc_o), 32'd0);
    check("rst_stb", 32'(wb.wbm_stb_o), 32'd0);
    check("we", 32'(wb.wbm_we_o), 32'd0);
    check("sel", 32'(wb.wbm_sel_o), 32'hF);
    check("dat_o", wb.wbm_dat_o, 32'd0);

    // second entry matches
    push_exp(1'b1, 1'b0, 1'b1, 8'd1, 32'hA000_0001, 32'hB000_1000, 32'h0000_0200);
    start_find(32'h0001_0002, 8'd0);
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done(2000);
    check("t1_reads", 32'(rd_log.size()), 32'd7);
    check("t1_adr2", log_at(2), 32'd8);
    check("t1_adr3", log_at(3), 32'd16);
    check("t1_adr6", log_at(6), 32'd19);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_found_held", 32'(found), 32'd1);

    // no match after scanning both entries
    do_reset();
    push_exp(1'b0, 1'b0, 1'b0, 8'd0, 32'h0, 32'h0, 32'h0);
    start_find(32'h0000_BEEF, 8'd0);
    wait_done(2000);
    check("t2_reads", 32'(rd_log.size()), 32'd4);
    check("t2_adr3", log_at(3), 32'd16);

    // three identical IDs, instance selection; upper bits of count word ignored
    rom[1] = 32'h1234_0003;
    set_entry(0, 32'h0000_0005, 32'hA000_0000, 32'hB000_0000, 32'h0000_0100);
    set_entry(1, 32'h0000_0005, 32'hA000_0001, 32'hB000_1000, 32'h0000_0200);
    set_entry(2, 32'h0000_0005, 32'hA000_0002, 32'hB000_2000, 32'h0000_0300);
    do_reset();
    push_exp(1'b1, 1'b0, 1'b1, 8'd2, 32'hA000_0002, 32'hB000_2000, 32'h0000_0300);
    start_find(32'h0000_0005, 8'd2);
    wait_done(2000);
    check("t3a_reads", 32'(rd_log.size()), 32'd8);
    do_reset();
    push_exp(1'b0, 1'b0, 1'b0, 8'd0, 32'h0, 32'h0, 32'h0);
    start_find(32'h0000_0005, 8'd3);
    wait_done(2000);
    check("t3b_reads", 32'(rd_log.size()), 32'd5);

    // bad header ID
    rom[0] = 32'hDEAD_0001;
    do_reset();
    push_exp(1'b0, 1'b1, 1'b0, 8'd0, 32'h0, 32'h0, 32'h0);
    start_find(32'h0000_0005, 8'd0);
    wait_done(2000);
    check("t4_reads", 32'(rd_log.size()), 32'd1);
    check("t4_adr0", log_at(0), 32'd0);

    // empty table
    rom[0] = 32'h0001_0001;
    rom[1] = 32'h0000_0100;
    do_reset();
    push_exp(1'b0, 1'b0, 1'b0, 8'd0, 32'h0, 32'h0, 32'h0);
    start_find(32'h0000_0005, 8'd0);
    wait_done(2000);
    check("t4b_reads", 32'(rd_log.size()), 32'd2);

    // slave never acks
    ack_en = 1'b0;
    do_reset();
    push_exp(1'b0, 1'b1, 1'b0, 8'd0, 32'h0, 32'h0, 32'h0);
    start_find(32'h0000_0005, 8'd0);
    for (int i = 0; i < 20 && !wb.wbm_cyc_o; i++) @(negedge clk);
    check("t5_stb_high", 32'(wb.wbm_stb_o), 32'd1);
    cnt = 0;
    while (wb.wbm_cyc_o && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check("t5_timeout_cycles", 32'(cnt), 32'd255);
    wait_done(10);
    check("t5_cyc_low", 32'(wb.wbm_cyc_o), 32'd0);
    check("t5_err_held", 32'(err), 32'd1);
    ack_en = 1'b1;

    // reset in the middle of a search
    load_two_entry_rom();
    do_reset();
    start_find(32'h0001_0002, 8'd0);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 20 && !wb.wbm_cyc_o; i++) @(negedge clk);
    check("t5b_cyc_before", 32'(wb.wbm_cyc_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5b_cyc_after_rst", 32'(wb.wbm_cyc_o), 32'd0);
    check("t5b_busy_after_rst", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (30) @(negedge clk);
    check("t5b_idle", 32'(busy), 32'd0);

    // back-to-back searches: header re-read only without the cache
    do_reset();
    push_exp(1'b1, 1'b0, 1'b1, 8'd1, 32'hA000_0001, 32'hB000_1000, 32'h0000_0200);
    start_find(32'h0001_0002, 8'd0);
    wait_done(2000);
    rd_log.delete();
    push_exp(1'b1, 1'b0, 1'b1, 8'd0, 32'hA000_0000, 32'hB000_0000, 32'h0000_0100);
    start_find(32'h0001_0005, 8'd0);
    wait_done(2000);
`ifdef DRT_FINDER_CACHE_EN
    check("t6_first_adr", log_at(0), 32'd8);
    check("t6_reads", 32'(rd_log.size()), 32'd4);
`else
    check("t6_first_adr", log_at(0), 32'd0);
    check("t6_reads", 32'(rd_log.size()), 32'd6);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
